// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder and its response buffer.
// Widths are fixed here because the tag struct is shared across module boundaries.
package imem_pkg;

   localparam int XLEN   = 32;
   localparam int HARTS  = 2;
   localparam int HART_W = (HARTS > 1) ? $clog2(HARTS) : 1;

   localparam int MEM_SIZE_BYTES    = 4096;
   localparam int DEFAULT_MEM_WORDS = MEM_SIZE_BYTES / 4;

   localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic [HART_W-1:0] hart;
      logic              err;
      logic              kill;
   } fetch_tag_t;

   typedef struct packed {
      fetch_tag_t      tag;
      logic [XLEN-1:0] inst;
   } rsp_entry_t;

   // A fetch is unservable when it is not word aligned or its word index falls past the BRAM.
   function automatic logic fetch_addr_bad(input logic [XLEN-1:0] addr, input int unsigned mem_words);
      return (addr[1:0] != 2'b00) || ((addr >> 2) >= XLEN'(mem_words));
   endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response buffer with per-hart kill marking, automatic discard of killed head entries, and an
// empty-buffer bypass so a response appears in the same cycle it is pushed.
module imem_rsp_fifo
   import imem_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  rsp_entry_t        push_entry,
   input  logic              flush_valid,
   input  logic [HART_W-1:0] flush_hart,
   input  logic              rsp_ready,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   head_inst,
   output logic [XLEN-1:0]   head_addr,
   output logic [HART_W-1:0] head_hart,
   output logic              head_err,
   output logic [CW-1:0]     count
);

   rsp_entry_t    mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   rsp_entry_t    head_raw;
   logic          empty;
   logic          has_head;
   logic          head_dead;
   logic          pop;
   logic          do_write;
   logic          do_advance;

   // A flush in this cycle must already hide a matching head, hence the combinational kill term.
   always_comb begin
      empty      = (count == '0);
      head_raw   = empty ? push_entry : mem[head];
      has_head   = !rst && (!empty || push);
      head_dead  = head_raw.tag.kill || (flush_valid && (head_raw.tag.hart == flush_hart));
      rsp_valid  = has_head && !head_dead;
      pop        = has_head && (head_dead || rsp_ready);
      do_write   = push && !(pop && empty);
      do_advance = pop && !empty;
      head_inst  = head_raw.inst;
      head_addr  = head_raw.tag.addr;
      head_hart  = head_raw.tag.hart;
      head_err   = head_raw.tag.err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (flush_valid && (mem[i].tag.hart == flush_hart)) begin
               mem[i].tag.kill <= 1'b1;
            end
         end
         if (do_write) begin
            mem[tail] <= push_entry;
            tail      <= tail + PW'(1);
         end
         if (do_advance) begin
            head <= head + PW'(1);
         end
         case ({do_write, do_advance})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imem_bram_responder.sv
// Instruction-fetch responder: credit-gated request acceptance, one-cycle BRAM stage (S1),
// and an ordered response buffer that keeps rsp_inst aligned with rsp_addr.
module imem_bram_responder
   import imem_pkg::*;
#(
   parameter  int MEM_WORDS = DEFAULT_MEM_WORDS,
   parameter  int OUT_DEPTH = 2,
   localparam int AW        = $clog2(MEM_WORDS),
   localparam int CW        = $clog2(OUT_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [HART_W-1:0] req_hart,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_inst,
   output logic [XLEN-1:0]   rsp_addr,
   output logic [HART_W-1:0] rsp_hart,
   output logic              rsp_err,
   input  logic              flush_valid,
   input  logic [HART_W-1:0] flush_hart,
   output logic              bram_en,
   output logic [AW-1:0]     bram_addr,
   input  logic [XLEN-1:0]   bram_rdata
);

   localparam logic [CW:0] DEPTH_CNT = (CW + 1)'(OUT_DEPTH);

   fetch_tag_t        s1_tag;
   logic              s1_valid;
   logic [CW-1:0]     buf_count;
   logic [CW:0]       used;
   logic              req_bad;
   logic              accept;
   rsp_entry_t        push_entry;
   logic              fifo_valid;
   logic [XLEN-1:0]   head_inst;
   logic [XLEN-1:0]   head_addr;
   logic [HART_W-1:0] head_hart;
   logic              head_err;

   // Credit rule: every accepted request already owns a buffer slot, so S1 can always drain.
   always_comb begin
      req_bad   = fetch_addr_bad(req_addr, MEM_WORDS);
      used      = {1'b0, buf_count} + {{CW{1'b0}}, s1_valid};
      req_ready = !rst && (used < DEPTH_CNT);
      accept    = req_valid && req_ready;
      bram_en   = accept && !req_bad;
      bram_addr = req_addr[AW+1:2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_tag   <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_tag <= '{addr: req_addr, hart: req_hart, err: req_bad, kill: 1'b0};
         end
      end
   end

   // Error entries carry a NOP and never look at bram_rdata, which is stale for them.
   always_comb begin
      push_entry          = '0;
      push_entry.tag      = s1_tag;
      push_entry.tag.kill = s1_tag.kill || (flush_valid && (s1_tag.hart == flush_hart));
      push_entry.inst     = s1_tag.err ? NOP_INST : bram_rdata;
   end

   imem_rsp_fifo #(
      .DEPTH (OUT_DEPTH)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (s1_valid),
      .push_entry  (push_entry),
      .flush_valid (flush_valid),
      .flush_hart  (flush_hart),
      .rsp_ready   (rsp_ready),
      .rsp_valid   (fifo_valid),
      .head_inst   (head_inst),
      .head_addr   (head_addr),
      .head_hart   (head_hart),
      .head_err    (head_err),
      .count       (buf_count)
   );

   always_comb begin
      rsp_valid = fifo_valid;
      rsp_inst  = fifo_valid ? head_inst : '0;
      rsp_addr  = fifo_valid ? head_addr : '0;
      rsp_hart  = fifo_valid ? head_hart : '0;
      rsp_err   = fifo_valid ? head_err  : 1'b0;
   end

endmodule

// File: tb/tb_imem_bram_responder.sv
// Self-checking bench for imem_bram_responder: directed scenarios plus a randomized run,
// all checked against an in-order queue model of accepted fetches.
module tb_imem_bram_responder;

   localparam int          MEM_WORDS = 256;
   localparam int          MEM_BYTES = MEM_WORDS * 4;
   localparam int          OUT_DEPTH = 4;
   localparam logic [31:0] NOP       = 32'h00000013;

   typedef struct {
      logic [31:0] addr;
      logic        hart;
      logic        err;
      logic [31:0] inst;
      int          cyc;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [0:0]  req_hart;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_inst;
   logic [31:0] rsp_addr;
   logic [0:0]  rsp_hart;
   logic        rsp_err;
   logic        flush_valid;
   logic [0:0]  flush_hart;
   logic        bram_en;
   logic [7:0]  bram_addr;
   logic [31:0] bram_rdata;

   logic [31:0] mem_arr [MEM_WORDS];

   rsp_t model_q [$];
   rsp_t got_q   [$];
   rsp_t exp_q   [$];

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   logic        obs_req_ready;
   logic        obs_rsp_valid;
   logic        obs_bram_en;
   logic [31:0] obs_rsp_inst;
   logic [31:0] obs_rsp_addr;
   logic        obs_rsp_hart;
   logic        obs_rsp_err;

   imem_bram_responder #(
      .MEM_WORDS (MEM_WORDS),
      .OUT_DEPTH (OUT_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_hart    (req_hart),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_inst    (rsp_inst),
      .rsp_addr    (rsp_addr),
      .rsp_hart    (rsp_hart),
      .rsp_err     (rsp_err),
      .flush_valid (flush_valid),
      .flush_hart  (flush_hart),
      .bram_en     (bram_en),
      .bram_addr   (bram_addr),
      .bram_rdata  (bram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bram_en) bram_rdata <= mem_arr[bram_addr];
   end

   function automatic rsp_t expect_rsp(input logic [31:0] a, input logic h);
      rsp_t e;
      e.addr = a;
      e.hart = h;
      e.err  = (a % 4 != 0) || (a >= MEM_BYTES);
      e.inst = NOP;
      if (!e.err) e.inst = mem_arr[a / 4];
      e.cyc  = 0;
      return e;
   endfunction

   // One clock cycle: drive at negedge, sample just after, and advance the queue model.
   task automatic tick(input logic r, input logic rv, input logic [31:0] ra, input logic rh,
                       input logic rr, input logic fv, input logic fh);
      @(negedge clk);
      rst = r; req_valid = rv; req_addr = ra; req_hart = rh;
      rsp_ready = rr; flush_valid = fv; flush_hart = fh;
      #1;
      obs_req_ready = req_ready;  obs_rsp_valid = rsp_valid; obs_bram_en = bram_en;
      obs_rsp_inst  = rsp_inst;   obs_rsp_addr  = rsp_addr;  obs_rsp_hart = rsp_hart;
      obs_rsp_err   = rsp_err;
      if (r) begin
         model_q.delete();
      end else begin
         if (fv) begin
            rsp_t keep [$];
            foreach (model_q[i]) if (model_q[i].hart != fh) keep.push_back(model_q[i]);
            model_q = keep;
         end
         if (rsp_valid && rr) begin
            got_q.push_back('{addr: rsp_addr, hart: rsp_hart, err: rsp_err, inst: rsp_inst, cyc: cyc});
            if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
         end
         if (rv && req_ready) model_q.push_back(expect_rsp(ra, rh));
      end
      cyc++;
   endtask

   task automatic drain(output bit timed_out);
      int n = 0;
      while (model_q.size() != 0 && n < 40) begin
         tick(0, 0, 0, 0, 1, 0, 0);
         n++;
      end
      timed_out = (model_q.size() != 0);
      repeat (3) tick(0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_reset();
      tick(1, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (obs_req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset req_ready: got %b, expected 0", obs_req_ready); end
      tests_run++;
      if (obs_rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset rsp_valid: got %b, expected 0", obs_rsp_valid); end
      tests_run++;
      if (obs_bram_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset bram_en: got %b, expected 0", obs_bram_en); end
      tick(0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (obs_req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post-reset req_ready: got %b, expected 1", obs_req_ready); end
      tests_run++;
      if (obs_rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL post-reset rsp_valid: got %b, expected 0", obs_rsp_valid); end
      tests_run++;
      if ({obs_rsp_inst, obs_rsp_addr, obs_rsp_hart, obs_rsp_err} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL post-reset rsp fields: got inst=%h addr=%h hart=%b err=%b, expected all 0",
                  obs_rsp_inst, obs_rsp_addr, obs_rsp_hart, obs_rsp_err);
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      int c0;
      got_q.delete(); exp_q.delete();
      c0 = cyc;
      for (int i = 0; i < 6; i++) tick(0, 1, 32'(i * 4), 0, 1, 0, 0);
      drain(to);
      tests_run++;
      if (to) begin tests_failed++; $display("[TB] FAIL b2b drain: %0d outstanding, expected 0", model_q.size()); end
      tests_run++;
      if (got_q.size() !== 6) begin tests_failed++; $display("[TB] FAIL b2b count: got %0d responses, expected 6", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
         tests_run++;
         if (got_q[i].cyc !== c0 + 1 + i || got_q[i].addr !== 32'(i * 4) ||
             got_q[i].inst !== (32'h00000013 | (32'(i + 1) << 20))) begin
            tests_failed++;
            $display("[TB] FAIL b2b rsp%0d: got cyc=%0d addr=%h inst=%h, expected cyc=%0d addr=%h inst=%h", i,
                     got_q[i].cyc, got_q[i].addr, got_q[i].inst, c0 + 1 + i, 32'(i * 4), 32'h00000013 | (32'(i + 1) << 20));
         end
      end
   endtask

   task automatic test_back_pressure();
      bit to;
      int idx = 0;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < OUT_DEPTH + 2; i++) begin
         tick(0, 1, 32'(idx * 4), 0, 0, 0, 0);
         tests_run++;
         if (obs_req_ready !== (i < OUT_DEPTH)) begin
            tests_failed++;
            $display("[TB] FAIL bp req_ready cycle %0d: got %b, expected %b", i, obs_req_ready, i < OUT_DEPTH);
         end
         if (i > 0) begin
            tests_run++;
            if (obs_rsp_valid !== 1'b1 || obs_rsp_addr !== 32'h0) begin
               tests_failed++;
               $display("[TB] FAIL bp stall hold cycle %0d: got valid=%b addr=%h, expected valid=1 addr=00000000", i, obs_rsp_valid, obs_rsp_addr);
            end
         end
         if (obs_req_ready) idx++;
      end
      drain(to);
      tests_run++;
      if (to) begin tests_failed++; $display("[TB] FAIL bp drain: %0d outstanding, expected 0", model_q.size()); end
      tests_run++;
      if (got_q.size() !== OUT_DEPTH) begin tests_failed++; $display("[TB] FAIL bp count: got %0d, expected %0d", got_q.size(), OUT_DEPTH); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (got_q[i].addr !== 32'(i * 4) || got_q[i].inst !== exp_q[i].inst || got_q[i].err !== exp_q[i].err) begin
            tests_failed++;
            $display("[TB] FAIL bp rsp%0d: got addr=%h inst=%h err=%b, expected addr=%h inst=%h err=%b", i,
                     got_q[i].addr, got_q[i].inst, got_q[i].err, 32'(i * 4), exp_q[i].inst, exp_q[i].err);
         end
      end
   endtask

   task automatic test_interleaved();
      bit to;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) tick(0, 1, 32'((i / 2) * 4), 0, 1, 0, 0);
         else            tick(0, 1, 32'h200 + 32'((i / 2) * 4), 1, 1, 0, 0);
      end
      drain(to);
      tests_run++;
      if (to) begin tests_failed++; $display("[TB] FAIL ilv drain: %0d outstanding, expected 0", model_q.size()); end
      tests_run++;
      if (got_q.size() !== 8) begin tests_failed++; $display("[TB] FAIL ilv count: got %0d, expected 8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (got_q[i].hart !== 1'(i % 2) || got_q[i].addr !== exp_q[i].addr || got_q[i].inst !== exp_q[i].inst) begin
            tests_failed++;
            $display("[TB] FAIL ilv rsp%0d: got hart=%0d addr=%h inst=%h, expected hart=%0d addr=%h inst=%h", i,
                     got_q[i].hart, got_q[i].addr, got_q[i].inst, i % 2, exp_q[i].addr, exp_q[i].inst);
         end
      end
      tests_run++;
      if (got_q.size() > 1 && got_q[1].inst !== 32'h00000063) begin
         tests_failed++;
         $display("[TB] FAIL ilv beq word: got %h, expected 00000063", got_q[1].inst);
      end
   endtask

   task automatic test_flush();
      bit to;
      got_q.delete(); exp_q.delete();
      tick(0, 1, 32'h0,   0, 0, 0, 0);
      tick(0, 1, 32'h200, 1, 0, 0, 0);
      tick(0, 1, 32'h4,   0, 0, 0, 0);
      tick(0, 1, 32'h8,   0, 0, 1, 0);
      tests_run++;
      if (obs_rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush head mask: got rsp_valid=%b, expected 0", obs_rsp_valid); end
      tests_run++;
      if (obs_req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush req_ready: got %b, expected 1", obs_req_ready); end
      drain(to);
      tests_run++;
      if (to) begin tests_failed++; $display("[TB] FAIL flush drain: %0d outstanding, expected 0", model_q.size()); end
      tests_run++;
      if (got_q.size() !== 2) begin tests_failed++; $display("[TB] FAIL flush count: got %0d, expected 2", got_q.size()); end
      tests_run++;
      if (got_q.size() == 2 && (got_q[0].addr !== 32'h200 || got_q[0].hart !== 1'b1 || got_q[0].inst !== 32'h63 ||
                                got_q[1].addr !== 32'h8 || got_q[1].hart !== 1'b0 || got_q[1].inst !== mem_arr[2])) begin
         tests_failed++;
         $display("[TB] FAIL flush survivors: got %h/h%0d/%h then %h/h%0d/%h, expected 00000200/h1/00000063 then 00000008/h0/%h",
                  got_q[0].addr, got_q[0].hart, got_q[0].inst, got_q[1].addr, got_q[1].hart, got_q[1].inst, mem_arr[2]);
      end
   endtask

   task automatic test_errors();
      bit to;
      logic [31:0] addrs [3];
      addrs[0] = 32'h2; addrs[1] = 32'(MEM_BYTES); addrs[2] = 32'h8;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, addrs[i], 1'(i % 2), 1, 0, 0);
         tests_run++;
         if (obs_bram_en !== !((addrs[i] % 4 != 0) || (addrs[i] >= MEM_BYTES))) begin
            tests_failed++;
            $display("[TB] FAIL err bram_en addr %h: got %b, expected %b", addrs[i], obs_bram_en, !((addrs[i] % 4 != 0) || (addrs[i] >= MEM_BYTES)));
         end
      end
      drain(to);
      tests_run++;
      if (to) begin tests_failed++; $display("[TB] FAIL err drain: %0d outstanding, expected 0", model_q.size()); end
      tests_run++;
      if (got_q.size() !== 3) begin tests_failed++; $display("[TB] FAIL err count: got %0d, expected 3", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (got_q[i].addr !== addrs[i] || got_q[i].err !== exp_q[i].err || got_q[i].inst !== exp_q[i].inst) begin
            tests_failed++;
            $display("[TB] FAIL err rsp%0d: got addr=%h err=%b inst=%h, expected addr=%h err=%b inst=%h", i,
                     got_q[i].addr, got_q[i].err, got_q[i].inst, addrs[i], exp_q[i].err, exp_q[i].inst);
         end
      end
   endtask

   task automatic test_reset_midflight();
      bit to;
      int stray = 0;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 3; i++) tick(0, 1, 32'h10 + 32'(i * 4), 0, 0, 0, 0);
      tick(1, 0, 0, 0, 1, 0, 0);
      tests_run++;
      if (obs_rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst reset cycle rsp_valid: got %b, expected 0", obs_rsp_valid); end
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0, 0, 1, 0, 0);
         if (obs_rsp_valid !== 1'b0) stray++;
      end
      tests_run++;
      if (stray !== 0) begin tests_failed++; $display("[TB] FAIL midrst stray responses: got %0d, expected 0", stray); end
      tick(0, 1, 32'h1c, 1, 1, 0, 0);
      drain(to);
      tests_run++;
      if (to) begin tests_failed++; $display("[TB] FAIL midrst drain: %0d outstanding, expected 0", model_q.size()); end
      tests_run++;
      if (got_q.size() !== 1 || got_q[0].addr !== 32'h1c || got_q[0].hart !== 1'b1 || got_q[0].inst !== mem_arr[7]) begin
         tests_failed++;
         $display("[TB] FAIL midrst new request: got %0d responses (first addr=%h), expected 1 at 0000001c inst=%h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0].addr : 32'hx, mem_arr[7]);
      end
   endtask

   task automatic test_random();
      bit to;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 400; i++) begin
         int          r = $urandom_range(0, 19);
         logic [31:0] a;
         if (r == 0)      a = 32'($urandom_range(0, MEM_WORDS - 1) * 4 + $urandom_range(1, 3));
         else if (r == 1) a = 32'(MEM_BYTES + $urandom_range(0, 15) * 4);
         else             a = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
         tick(0, $urandom_range(0, 9) < 7, a, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
              $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
      end
      drain(to);
      tests_run++;
      if (to) begin tests_failed++; $display("[TB] FAIL rand drain: %0d outstanding, expected 0", model_q.size()); end
      tests_run++;
      if (got_q.size() !== exp_q.size() || got_q.size() == 0) begin
         tests_failed++;
         $display("[TB] FAIL rand count: got %0d responses, expected %0d (nonzero)", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].inst !== exp_q[i].inst ||
             got_q[i].hart !== exp_q[i].hart || got_q[i].err !== exp_q[i].err) begin
            tests_failed++;
            $display("[TB] FAIL rand rsp%0d: got addr=%h inst=%h hart=%0d err=%b, expected addr=%h inst=%h hart=%0d err=%b", i,
                     got_q[i].addr, got_q[i].inst, got_q[i].hart, got_q[i].err,
                     exp_q[i].addr, exp_q[i].inst, exp_q[i].hart, exp_q[i].err);
         end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_hart = '0;
      rsp_ready = 1'b0; flush_valid = 1'b0; flush_hart = '0; bram_rdata = '0;
      for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = $urandom;
      for (int i = 0; i < 6; i++) mem_arr[i] = 32'h00000013 | (32'(i + 1) << 20);
      mem_arr[128] = 32'h00000063;

      test_reset();
      test_back_to_back();
      test_back_pressure();
      test_interleaved();
      test_flush();
      test_errors();
      test_reset_midflight();
      test_random();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
